// File: rtl/input_conditioner_if.sv
// Board-input conditioner bus: raw inputs in, conditioned levels, edge pulses and shared tick out.
// The master side drives raw_in and consumes the rest; the conditioner sits on the slave side.
interface input_conditioner_if #(
   parameter int unsigned N_CH = 4
);
   logic [N_CH-1:0] raw_in;
   logic            tick;
   logic [N_CH-1:0] level_out;
   logic [N_CH-1:0] rise_pulse;
   logic [N_CH-1:0] fall_pulse;
   logic            changed;

   modport master (
      output raw_in,
      input  tick,
      input  level_out,
      input  rise_pulse,
      input  fall_pulse,
      input  changed
   );

   modport slave (
      input  raw_in,
      output tick,
      output level_out,
      output rise_pulse,
      output fall_pulse,
      output changed
   );
endinterface

// File: rtl/input_conditioner.sv
// Per-channel synchroniser, tick-qualified debounce and registered rise/fall pulses for
// board-level inputs; also exports the shared slow tick used as the downstream enable.
module input_conditioner #(
   parameter int unsigned    N_CH           = 4,
   parameter int unsigned    SYNC_STAGES    = 2,
   parameter int unsigned    DIVIDER        = 2_500_000,
   parameter int unsigned    DEBOUNCE_TICKS = 3,
   parameter logic [N_CH-1:0] INIT_LEVEL    = '0
) (
   input logic                 clk,
   input logic                 reset,
   input_conditioner_if.slave  bus
);

   localparam int unsigned TickW = (DIVIDER > 0) ? $clog2(DIVIDER + 1) : 1;
   localparam logic [TickW-1:0] TickMax = TickW'(DIVIDER);

   // ---------------------------------------------------------------- tick generator
   logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
   logic             tick_q;

   always_comb begin
      tick_cnt_d = tick_cnt_q + 1'b1;
      if (tick_cnt_q == TickMax) begin
         tick_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt_q <= '0;
         tick_q     <= 1'b0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         tick_q     <= (tick_cnt_q == TickMax);
      end
   end

   // ---------------------------------------------------------------- synchroniser
   logic [N_CH-1:0] sync_q [SYNC_STAGES];
   logic [N_CH-1:0] sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= INIT_LEVEL;
         end
      end else begin
         sync_q[0] <= bus.raw_in;
         for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   // ---------------------------------------------------------------- debounce
   logic [N_CH-1:0] level_q, level_d;
   logic [N_CH-1:0] rise_q, fall_q;

   if (DEBOUNCE_TICKS == 0) begin : g_bypass
      assign level_d = sync;
   end else begin : g_debounce
      localparam int unsigned CntW = $clog2(DEBOUNCE_TICKS + 1);
      localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_TICKS - 1);

      logic [CntW-1:0] cnt_q [N_CH];
      logic [CntW-1:0] cnt_d [N_CH];

      // A channel is accepted on the tick that would bring its disagreement count to
      // DEBOUNCE_TICKS; any cycle of agreement throws the partial count away.
      always_comb begin
         level_d = level_q;
         for (int unsigned ch = 0; ch < N_CH; ch++) begin
            cnt_d[ch] = cnt_q[ch];
            if (sync[ch] == level_q[ch]) begin
               cnt_d[ch] = '0;
            end else if (tick_q) begin
               if (cnt_q[ch] == CntLast) begin
                  level_d[ch] = sync[ch];
                  cnt_d[ch]   = '0;
               end else begin
                  cnt_d[ch] = cnt_q[ch] + 1'b1;
               end
            end
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
               cnt_q[ch] <= '0;
            end
         end else begin
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
               cnt_q[ch] <= cnt_d[ch];
            end
         end
      end
   end

   // ---------------------------------------------------------------- level and edge pulses
   // Pulses are registered with the level so they line up with the new level_out value.
   always_ff @(posedge clk) begin
      if (reset) begin
         level_q <= INIT_LEVEL;
         rise_q  <= '0;
         fall_q  <= '0;
      end else begin
         level_q <= level_d;
         rise_q  <= level_d & ~level_q;
         fall_q  <= ~level_d & level_q;
      end
   end

   assign bus.tick       = tick_q;
   assign bus.level_out  = level_q;
   assign bus.rise_pulse = rise_q;
   assign bus.fall_pulse = fall_q;
   assign bus.changed    = |(rise_q | fall_q);

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: a debounced instance and a bypass instance, each checked every
// cycle against a cycle-count based reference model, plus directed literal checks.
module tb_input_conditioner;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, rst_b;
   logic [3:0] raw_a, raw_b;

   input_conditioner_if #(.N_CH(4)) bus_a ();
   input_conditioner_if #(.N_CH(4)) bus_b ();

   assign bus_a.raw_in = raw_a;
   assign bus_b.raw_in = raw_b;

   input_conditioner #(
      .N_CH(4), .SYNC_STAGES(2), .DIVIDER(4), .DEBOUNCE_TICKS(3), .INIT_LEVEL(4'b0000)
   ) dut_a (
      .clk(clk), .reset(rst_a), .bus(bus_a)
   );

   input_conditioner #(
      .N_CH(4), .SYNC_STAGES(2), .DIVIDER(0), .DEBOUNCE_TICKS(0), .INIT_LEVEL(4'b0000)
   ) dut_b (
      .clk(clk), .reset(rst_b), .bus(bus_b)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- reference model
   typedef struct packed {
      int unsigned       cyc;   // clocks since reset release
      logic [7:0][3:0]   hist;  // hist[k] = raw_in sampled k+1 clocks ago
      logic [3:0]        level;
      logic [3:0][7:0]   cnt;   // ticks seen while disagreeing
      logic              tick;
      logic [3:0]        rise;
      logic [3:0]        fall;
   } mstate_t;

   function automatic mstate_t model_step(input mstate_t s, input logic rst, input logic [3:0] raw,
                                          input int unsigned div, input int unsigned dt,
                                          input int unsigned stages, input logic [3:0] init);
      mstate_t    n;
      logic [3:0] sync_now;
      n = s;
      if (rst) begin
         n.cyc = 0;
         for (int k = 0; k < 8; k++) n.hist[k] = init;
         n.level = init;
         n.cnt   = '0;
         n.tick  = 1'b0;
         n.rise  = '0;
         n.fall  = '0;
         return n;
      end
      sync_now = s.hist[stages-1];
      n.cyc  = s.cyc + 1;
      n.tick = ((n.cyc % (div + 1)) == 0);
      for (int ch = 0; ch < 4; ch++) begin
         if (dt == 0) begin
            n.level[ch] = sync_now[ch];
         end else if (sync_now[ch] == s.level[ch]) begin
            n.cnt[ch] = 8'd0;
         end else if (s.tick) begin
            if (32'(s.cnt[ch]) + 1 == dt) begin
               n.level[ch] = sync_now[ch];
               n.cnt[ch]   = 8'd0;
            end else begin
               n.cnt[ch] = s.cnt[ch] + 8'd1;
            end
         end
      end
      n.rise = n.level & ~s.level;
      n.fall = ~n.level & s.level;
      for (int k = 7; k > 0; k--) n.hist[k] = s.hist[k-1];
      n.hist[0] = raw;
      return n;
   endfunction

   mstate_t ms_a, ms_b;
   bit      armed_a = 1'b0, armed_b = 1'b0;

   always @(posedge clk) begin
      ms_a <= model_step(ms_a, rst_a, raw_a, 4, 3, 2, 4'b0000);
      ms_b <= model_step(ms_b, rst_b, raw_b, 0, 0, 2, 4'b0000);
      if (rst_a) armed_a <= 1'b1;
      if (rst_b) armed_b <= 1'b1;
   end

   always @(negedge clk) begin
      if (armed_a) begin
         check("a.tick",  32'(bus_a.tick),       32'(ms_a.tick));
         check("a.level", 32'(bus_a.level_out),  32'(ms_a.level));
         check("a.rise",  32'(bus_a.rise_pulse), 32'(ms_a.rise));
         check("a.fall",  32'(bus_a.fall_pulse), 32'(ms_a.fall));
         check("a.chg",   32'(bus_a.changed),    32'(|(ms_a.rise | ms_a.fall)));
      end
      if (armed_b) begin
         check("b.tick",  32'(bus_b.tick),       32'(ms_b.tick));
         check("b.level", 32'(bus_b.level_out),  32'(ms_b.level));
         check("b.rise",  32'(bus_b.rise_pulse), 32'(ms_b.rise));
         check("b.fall",  32'(bus_b.fall_pulse), 32'(ms_b.fall));
         check("b.chg",   32'(bus_b.changed),    32'(|(ms_b.rise | ms_b.fall)));
      end
   end

   // ---------------------------------------------------------------- stimulus
   // Sync rises 2 clocks after the raw change; ticks land at clocks 6, 11, 16 from that point.
   localparam int PressLat = 16;

   function automatic int pick_hold(input bit long_ok);
      if (!long_ok || $urandom_range(0, 3) == 0) return int'($urandom_range(1, 4));
      return int'($urandom_range(12, 45));
   endfunction

   int nfall;
   int hold_a, hold_b, rcnt_a, rcnt_b;

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      raw_a = 4'hf;
      raw_b = 4'hf;
      repeat (3) begin
         @(negedge clk);
         check("rst_level_a", 32'(bus_a.level_out), 32'h0);
         check("rst_pulse_a", 32'(bus_a.rise_pulse | bus_a.fall_pulse), 32'h0);
         check("rst_tick_a",  32'(bus_a.tick), 32'h0);
         check("rst_level_b", 32'(bus_b.level_out), 32'h0);
      end
      raw_a = 4'h0;
      raw_b = 4'h0;
      rst_a = 1'b0;
      rst_b = 1'b0;

      // Tick phase after release.
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         check("tick_phase_a", 32'(bus_a.tick), 32'((k % 5) == 0));
         check("tick_const_b", 32'(bus_b.tick), 32'h1);
      end

      // Clean press on channel 0.
      raw_a[0] = 1'b1;
      for (int m = 1; m <= PressLat + 1; m++) begin
         @(negedge clk);
         check("press_level0", 32'(bus_a.level_out[0]), 32'(m >= PressLat));
         check("press_rise",   32'(bus_a.rise_pulse), (m == PressLat) ? 32'h1 : 32'h0);
         check("press_chg",    32'(bus_a.changed), 32'(m == PressLat));
         check("press_others", 32'(bus_a.level_out[3:1]), 32'h0);
      end

      // Short glitch between ticks, then a glitch spanning two ticks.
      repeat (2) @(negedge clk);
      raw_a[1] = 1'b1;
      repeat (3) @(negedge clk);
      raw_a[1] = 1'b0;
      for (int m = 0; m < 12; m++) begin
         @(negedge clk);
         check("glitch_level1", 32'(bus_a.level_out[1]), 32'h0);
         check("glitch_rise1",  32'(bus_a.rise_pulse[1]), 32'h0);
      end
      raw_a[1] = 1'b1;
      repeat (10) @(negedge clk);
      raw_a[1] = 1'b0;
      for (int m = 0; m < 20; m++) begin
         @(negedge clk);
         check("long_glitch_level1", 32'(bus_a.level_out[1]), 32'h0);
      end

      // Channels 0 and 2 both held, then dropped together.
      raw_a[2] = 1'b1;
      repeat (25) @(negedge clk);
      check("both_held", 32'(bus_a.level_out), 32'h5);
      raw_a[0] = 1'b0;
      raw_a[2] = 1'b0;
      nfall = 0;
      for (int m = 0; m < 25; m++) begin
         @(negedge clk);
         if (bus_a.fall_pulse != 4'h0) begin
            nfall++;
            check("fall_both", 32'(bus_a.fall_pulse), 32'h5);
            check("fall_chg",  32'(bus_a.changed), 32'h1);
         end
      end
      check("fall_count",   32'(nfall), 32'h1);
      check("fall_level",   32'(bus_a.level_out), 32'h0);

      // Reset after two ticks of a pending press on channel 3.
      raw_a[3] = 1'b1;
      repeat (14) @(negedge clk);
      rst_a = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst_level", 32'(bus_a.level_out), 32'h0);
      rst_a = 1'b0;
      for (int k = 1; k <= PressLat + 1; k++) begin
         @(negedge clk);
         check("requal_level3", 32'(bus_a.level_out[3]), 32'(k >= PressLat));
         check("requal_rise3",  32'(bus_a.rise_pulse[3]), 32'(k == PressLat));
      end

      // Bypass: a one-clock raw pulse comes out as rise then fall on consecutive clocks.
      raw_b[0] = 1'b1;
      @(negedge clk);
      raw_b[0] = 1'b0;
      for (int m = 2; m <= 5; m++) begin
         @(negedge clk);
         check("byp_level", 32'(bus_b.level_out), (m == 3) ? 32'h1 : 32'h0);
         check("byp_rise",  32'(bus_b.rise_pulse), (m == 3) ? 32'h1 : 32'h0);
         check("byp_fall",  32'(bus_b.fall_pulse), (m == 4) ? 32'h1 : 32'h0);
      end

      // Random phase with occasional resets.
      hold_a = 0;
      hold_b = 0;
      rcnt_a = 0;
      rcnt_b = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (hold_a == 0) begin
            raw_a  = raw_a ^ 4'($urandom_range(1, 15));
            hold_a = pick_hold(1'b1);
         end else begin
            hold_a--;
         end
         if (hold_b == 0) begin
            raw_b  = raw_b ^ 4'($urandom_range(1, 15));
            hold_b = pick_hold(1'b0);
         end else begin
            hold_b--;
         end
         rst_a = (rcnt_a > 0);
         if (rcnt_a > 0) rcnt_a--;
         else if ($urandom_range(0, 599) == 0) rcnt_a = int'($urandom_range(1, 3));
         rst_b = (rcnt_b > 0);
         if (rcnt_b > 0) rcnt_b--;
         else if ($urandom_range(0, 599) == 0) rcnt_b = int'($urandom_range(1, 3));
      end
      rst_a = 1'b0;
      rst_b = 1'b0;
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
